// File: rtl/rtsnoc_local_port_arbiter.sv
// Shares one RTSNoC router local port between NUM_REQ requesters.
// TX: round-robin arbiter feeding a registered one-flit holding stage.
// RX: router flits steered by a header select field into one-entry slots.
module rtsnoc_local_port_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned SOC_SIZE_X     = 1,
  parameter int unsigned SOC_SIZE_Y     = 1,
  parameter int unsigned NOC_DATA_WIDTH = 16,
  parameter int unsigned DEMUX_LSB      = 0,
  localparam int unsigned NOC_BUS_SIZE  = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NUM_REQ-1:0]              req_wr_i,
  input  logic [NUM_REQ*NOC_BUS_SIZE-1:0] req_din_i,
  output logic [NUM_REQ-1:0]              req_ack_o,
  output logic [NUM_REQ-1:0]              req_nd_o,
  output logic [NUM_REQ*NOC_BUS_SIZE-1:0] req_dout_o,
  input  logic [NUM_REQ-1:0]              req_rd_i,
  output logic [NOC_BUS_SIZE-1:0]         noc_din_o,
  output logic                            noc_wr_o,
  input  logic                            noc_wait_i,
  input  logic [NOC_BUS_SIZE-1:0]         noc_dout_i,
  input  logic                            noc_nd_i,
  output logic                            noc_rd_o,
  output logic [7:0]                      drop_cnt_o
);

  localparam int unsigned SELW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StEmpty, StFull} tx_state_e;

  tx_state_e                                tx_state_q;
  logic [NOC_BUS_SIZE-1:0]                  tx_flit_q;
  logic [NUM_REQ-1:0]                       req_ack_q, ack_d;
  logic [SELW-1:0]                          last_q, grant_idx;
  logic                                     grant_valid;
  logic                                     tx_free;
  int unsigned                              cand;

  logic [SELW-1:0]                          sel;
  logic                                     sel_ok;
  logic                                     slot_busy;
  logic [NUM_REQ-1:0]                       slot_nd_q, slot_nd_d;
  logic [NUM_REQ-1:0][NOC_BUS_SIZE-1:0]     slot_data_q, slot_data_d;
  logic [7:0]                               drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------------- TX path
  // The holding stage can accept a new flit if empty or drained this cycle.
  assign tx_free = (tx_state_q == StEmpty) | ~noc_wait_i;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_q;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!grant_valid && req_wr_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(cand);
      end
    end
  end

  // One-cycle ack to the requester whose flit enters the holding stage.
  always_comb begin
    ack_d = '0;
    if (tx_free && grant_valid) ack_d[grant_idx] = 1'b1;
  end

  // Holding-stage FSM, ack pulse and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q <= StEmpty;
      tx_flit_q  <= '0;
      req_ack_q  <= '0;
      last_q     <= SELW'(NUM_REQ - 1);
    end else begin
      req_ack_q <= ack_d;
      if (tx_free) begin
        if (grant_valid) begin
          tx_state_q <= StFull;
          tx_flit_q  <= req_din_i[32'(grant_idx)*NOC_BUS_SIZE +: NOC_BUS_SIZE];
          last_q     <= grant_idx;
        end else begin
          tx_state_q <= StEmpty;
        end
      end
    end
  end

  assign noc_wr_o  = (tx_state_q == StFull);
  assign noc_din_o = tx_flit_q;
  assign req_ack_o = req_ack_q;

  // ---------------------------------------------------------------- RX path
  assign sel    = noc_dout_i[DEMUX_LSB +: SELW];
  assign sel_ok = 32'(sel) < NUM_REQ;

  // Target slot is occupied and not being emptied this cycle: stall the head.
  always_comb begin
    slot_busy = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(sel) == i && slot_nd_q[i] && !req_rd_i[i]) slot_busy = 1'b1;
    end
  end

  // Gated by reset so the router is never popped while the slots are held clear.
  assign noc_rd_o = rst_n_i & noc_nd_i & ~slot_busy;

  // Slot pop/refill and saturating drop counter next state.
  always_comb begin
    slot_nd_d   = slot_nd_q & ~req_rd_i;
    slot_data_d = slot_data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (noc_rd_o && 32'(sel) == i) begin
        slot_nd_d[i]   = 1'b1;
        slot_data_d[i] = noc_dout_i;
      end
    end
    drop_cnt_d = drop_cnt_q;
    if (noc_rd_o && !sel_ok && drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // RX slot and drop counter state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_nd_q   <= '0;
      slot_data_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      slot_nd_q   <= slot_nd_d;
      slot_data_q <= slot_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign req_nd_o   = slot_nd_q;
  assign req_dout_o = slot_data_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
